// File: rtl/sbus_transfer_controller.sv
// S-bus transfer sequencer: round-robin arbitration of two requesters, then a
// DRIVE/STORE/DONE pulse train that strobes one switchable register per command.
module sbus_transfer_controller #(
  parameter int NREG = 8,
  parameter int AW   = 3,
  parameter int W    = 16
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [3:0]        req_op,
  input  logic [2*AW-1:0]   req_src,
  input  logic [2*AW-1:0]   req_dst,
  input  logic [2*W-1:0]    req_imm,
  output logic [NREG-1:0]   SR,
  output logic [1:0]        bus_sel,
  output logic [AW-1:0]     src_sel,
  output logic [W-1:0]      imm_out,
  output logic              busy,
  output logic              done,
  output logic              done_id,
  output logic              err
);

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_STORE, ST_DONE} state_t;

  localparam logic [1:0]  OP_MOVE  = 2'b00;
  localparam logic [1:0]  OP_LOAD  = 2'b01;
  localparam logic [1:0]  OP_RSVD  = 2'b11;
  localparam logic [AW:0] NREG_LIM = (AW+1)'(NREG);

  state_t          r_state;
  state_t          w_next;
  logic            r_rr;
  logic            r_id;
  logic            r_ill;
  logic [AW-1:0]   r_dst;

  logic            w_open;
  logic            w_take;
  logic            w_gid;
  logic [1:0]      w_op;
  logic [AW-1:0]   w_src;
  logic [AW-1:0]   w_dst;
  logic [W-1:0]    w_imm;
  logic [NREG-1:0] w_sr_hot;

  // Commands are only taken while no transfer owns the bus, and never during reset.
  assign w_open = ~CLR & ((r_state == ST_IDLE) | (r_state == ST_DONE));

  always_comb begin
    w_gid = req_valid[1];
    if (&req_valid) w_gid = r_rr;
  end

  assign w_take    = w_open & (|req_valid);
  assign req_ready = w_take ? (w_gid ? 2'b10 : 2'b01) : 2'b00;

  assign w_op  = w_gid ? req_op[3:2]          : req_op[1:0];
  assign w_src = w_gid ? req_src[2*AW-1:AW]   : req_src[AW-1:0];
  assign w_dst = w_gid ? req_dst[2*AW-1:AW]   : req_dst[AW-1:0];
  assign w_imm = w_gid ? req_imm[2*W-1:W]     : req_imm[W-1:0];

  assign w_sr_hot = {{(NREG-1){1'b0}}, 1'b1} << r_dst;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_take) w_next = ST_DRIVE;
      ST_DRIVE: w_next = ST_STORE;
      ST_STORE: w_next = ST_DONE;
      ST_DONE:  w_next = w_take ? ST_DRIVE : ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_rr    <= 1'b0;
      r_id    <= 1'b0;
      r_ill   <= 1'b0;
      r_dst   <= '0;
      SR      <= '0;
      bus_sel <= 2'b00;
      src_sel <= '0;
      imm_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (w_take) begin
        r_rr    <= ~w_gid;
        r_id    <= w_gid;
        r_dst   <= w_dst;
        r_ill   <= (w_op == OP_RSVD) | ({1'b0, w_dst} >= NREG_LIM);
        src_sel <= w_src;
        case (w_op)
          OP_MOVE: begin bus_sel <= 2'b00; imm_out <= '0;    end
          OP_LOAD: begin bus_sel <= 2'b01; imm_out <= w_imm; end
          default: begin bus_sel <= 2'b10; imm_out <= '0;    end
        endcase
      end
      // Strobe only for the STORE cycle, and never for an illegal command.
      SR   <= ((w_next == ST_STORE) && !r_ill) ? w_sr_hot : '0;
      busy <= (w_next == ST_DRIVE) || (w_next == ST_STORE);
      done <= (w_next == ST_DONE);
      err  <= (w_next == ST_DONE) && r_ill;
      if (w_next == ST_DONE) done_id <= r_id;
    end
  end

endmodule

// File: tb/tb_sbus_transfer_controller.sv
// Bench for sbus_transfer_controller: directed scenarios plus random traffic,
// checked each cycle against a transaction-level model of the transfer protocol.
module tb_sbus_transfer_controller;
  localparam int NREG = 6;
  localparam int AW   = 3;
  localparam int W    = 16;

  logic            CLK = 1'b0;
  logic            CLR = 1'b1;
  logic [1:0]      req_valid = '0;
  logic [1:0]      req_ready;
  logic [3:0]      req_op = '0;
  logic [2*AW-1:0] req_src = '0;
  logic [2*AW-1:0] req_dst = '0;
  logic [2*W-1:0]  req_imm = '0;
  logic [NREG-1:0] SR;
  logic [1:0]      bus_sel;
  logic [AW-1:0]   src_sel;
  logic [W-1:0]    imm_out;
  logic            busy, done, done_id, err;

  sbus_transfer_controller #(.NREG(NREG), .AW(AW), .W(W)) dut (
    .CLK(CLK), .CLR(CLR), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_src(req_src), .req_dst(req_dst), .req_imm(req_imm),
    .SR(SR), .bus_sel(bus_sel), .src_sel(src_sel), .imm_out(imm_out),
    .busy(busy), .done(done), .done_id(done_id), .err(err)
  );

  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: m_t counts cycles since accept (0 = nothing in flight, 1..3 = DRIVE/STORE/DONE).
  int          m_t  = 0;
  int          m_rr = 0;
  int          m_id = 0;
  logic [1:0]  m_op = '0;
  logic [2:0]  m_src = '0;
  logic [2:0]  m_dst = '0;
  logic [15:0] m_imm = '0;
  logic        m_ill = 1'b0;

  // 0: drop valid after accept, 1: keep re-issuing, 2: random traffic
  int policy = 0;

  int sr_log[$];
  int done_log[$];
  int err_log[$];
  int acc_log[$];
  int acc_in_done = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [2:0] src,
                         input logic [2:0] dst, input logic [15:0] imm);
    req_valid[i]        = 1'b1;
    req_op[i*2 +: 2]    = op;
    req_src[i*3 +: 3]   = src;
    req_dst[i*3 +: 3]   = dst;
    req_imm[i*16 +: 16] = imm;
  endtask

  task automatic new_rand(input int i);
    logic [1:0] op;
    op = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    set_req(i, op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 16'($urandom));
  endtask

  task automatic clear_logs();
    sr_log.delete(); done_log.delete(); err_log.delete(); acc_log.delete();
    acc_in_done = 0;
  endtask

  // Called at a negedge with inputs settled; returns at the following negedge.
  task automatic step();
    logic [1:0]  er;
    logic [31:0] esr;
    int          w;
    #1;
    if (CLR) begin m_t = 0; m_rr = 0; end
    er = 2'b00;
    w  = -1;
    if (!CLR && (m_t == 0 || m_t == 3)) begin
      if (req_valid == 2'b11) w = m_rr;
      else if (req_valid[0])  w = 0;
      else if (req_valid[1])  w = 1;
      if (w >= 0) er[w] = 1'b1;
    end
    chk("ready", 32'(req_ready), 32'(er));
    if (CLR) begin
      chk("rst_sr", 32'(SR), 0);        chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);    chk("rst_err", 32'(err), 0);
      chk("rst_done_id", 32'(done_id), 0);
      chk("rst_bus_sel", 32'(bus_sel), 0);
      chk("rst_src_sel", 32'(src_sel), 0);
      chk("rst_imm_out", 32'(imm_out), 0);
    end else begin
      esr = (m_t == 2 && !m_ill) ? (32'd1 << m_dst) : 32'd0;
      chk("sr", 32'(SR), esr);
      chk("busy", 32'(busy), 32'(m_t == 1 || m_t == 2));
      chk("done", 32'(done), 32'(m_t == 3));
      chk("err", 32'(err), 32'(m_t == 3 && m_ill));
      if (m_t == 3) chk("done_id", 32'(done_id), 32'(m_id));
      if (m_t != 0 && m_op != 2'd3) begin
        chk("bus_sel", 32'(bus_sel), 32'(m_op));
        if (m_op == 2'd0) chk("src_sel", 32'(src_sel), 32'(m_src));
        else chk("imm_out", 32'(imm_out), (m_op == 2'd1) ? 32'(m_imm) : 32'd0);
      end
    end
    if (SR != 0) sr_log.push_back(cyc);
    if (done) begin done_log.push_back(int'(done_id)); err_log.push_back(int'(err)); end
    if (req_ready != 0) acc_log.push_back(cyc);
    if (done && req_ready != 0) acc_in_done++;
    @(posedge CLK);
    cyc++;
    if (!CLR) begin
      if (w >= 0) begin
        m_id  = w;
        m_op  = req_op[w*2 +: 2];
        m_src = req_src[w*3 +: 3];
        m_dst = req_dst[w*3 +: 3];
        m_imm = req_imm[w*16 +: 16];
        m_ill = (m_op == 2'd3) || (int'(m_dst) >= NREG);
        m_rr  = 1 - w;
        m_t   = 1;
      end else if (m_t == 3) m_t = 0;
      else if (m_t != 0) m_t++;
    end
    @(negedge CLK);
    if (w >= 0) begin
      if (policy == 0) req_valid[w] = 1'b0;
      else if (policy == 2) begin
        if ($urandom_range(0, 1) == 1) new_rand(w);
        else req_valid[w] = 1'b0;
      end
    end
    if (policy == 2)
      for (int i = 0; i < 2; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0) new_rand(i);
  endtask

  task automatic do_reset();
    CLR = 1'b1; step(); step(); CLR = 1'b0;
  endtask

  initial begin
    @(negedge CLK);
    // Reset, including a pending request that must not be acknowledged
    step();
    set_req(0, 2'd1, 3'd0, 3'd3, 16'hA5A5);
    step();
    CLR = 1'b0;

    // 1: single LOAD
    clear_logs();
    for (int k = 0; k < 6; k++) step();
    chk("t1_sr_pulses", 32'(sr_log.size()), 1);
    chk("t1_sr_cycle", 32'(sr_log[0] - acc_log[0]), 2);
    chk("t1_done_count", 32'(done_log.size()), 1);
    chk("t1_done_id", 32'(done_log[0]), 0);

    // 2: both requesters continuously valid
    do_reset();
    clear_logs();
    policy = 1;
    set_req(0, 2'd0, 3'd1, 3'd2, 16'h0);
    set_req(1, 2'd0, 3'd1, 3'd2, 16'h0);
    for (int k = 0; k < 12; k++) step();
    req_valid = 2'b00;
    policy = 0;
    for (int k = 0; k < 4; k++) step();
    chk("t2_done_count", 32'(done_log.size()), 4);
    for (int i = 0; i < 4; i++) chk("t2_done_id_seq", 32'(done_log[i]), 32'(i % 2));
    for (int i = 1; i < 4; i++) chk("t2_sr_spacing", 32'(sr_log[i] - sr_log[i-1]), 3);

    // 3: illegal commands from requester 1
    clear_logs();
    set_req(1, 2'd3, 3'd0, 3'd1, 16'h1234);
    for (int k = 0; k < 5; k++) step();
    set_req(1, 2'd0, 3'd1, 3'd7, 16'h0);
    for (int k = 0; k < 5; k++) step();
    chk("t3_no_sr", 32'(sr_log.size()), 0);
    chk("t3_done_count", 32'(done_log.size()), 2);
    chk("t3_err_count", 32'(err_log.sum()), 2);

    // 4: reset during STORE of CLEAR dst=5
    clear_logs();
    set_req(0, 2'd2, 3'd0, 3'd5, 16'hFFFF);
    for (int k = 0; k < 10 && m_t != 2; k++) step();
    #1;
    chk("t4_sr_store", 32'(SR), 32'h20);
    CLR = 1'b1;
    #1;
    chk("t4_sr_async", 32'(SR), 0);
    chk("t4_busy_async", 32'(busy), 0);
    step();
    CLR = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("t4_no_done", 32'(done_log.size()), 0);
    set_req(0, 2'd1, 3'd0, 3'd0, 16'h0F0F);
    set_req(1, 2'd1, 3'd0, 3'd1, 16'hF0F0);
    #1;
    chk("t4_rr_restart", 32'(req_ready), 32'h1);
    for (int k = 0; k < 8; k++) step();

    // 5: back-to-back from one requester, accepted in DONE
    clear_logs();
    policy = 1;
    set_req(0, 2'd1, 3'd0, 3'd1, 16'($urandom));
    for (int k = 0; k < 10; k++) step();
    req_valid = 2'b00;
    policy = 0;
    for (int k = 0; k < 4; k++) step();
    chk("t5_acc_in_done", 32'(acc_in_done), 3);
    for (int i = 1; i < 4; i++) chk("t5_acc_spacing", 32'(acc_log[i] - acc_log[i-1]), 3);

    // Random traffic with occasional resets
    policy = 2;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      else step();
    end
    policy = 0;
    for (int k = 0; k < 20; k++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
